// File: rtl/ring_inject_sched.sv
// Round-robin injection scheduler: four local requesters share one
// ring injection port, each packet held HOLD cycles with a toggle bit.
// Ports: clk, rst_n (async, active-low), en, ring_stall, req_mask[3:0],
//   req_valid[3:0], req_data[23:0] (6 bits per requester: dest[5:4],
//   data[3:0]) -> req_ready[3:0] (comb one-hot grant), inj_data[7:0],
//   inj_strobe, busy, pkt_count[7:0] (all registered).
module ring_inject_sched #(
    parameter int unsigned HOLD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        ring_stall,
    input  logic [3:0]  req_mask,
    input  logic [3:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [3:0]  req_ready,
    output logic [7:0]  inj_data,
    output logic        inj_strobe,
    output logic        busy,
    output logic [7:0]  pkt_count
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic       tog_q, tog_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] inj_data_q, inj_data_d;
    logic       strobe_q, strobe_d;
    logic [7:0] pkt_count_q, pkt_count_d;

    logic [3:0] elig;
    logic       gnt_any;
    logic [1:0] gnt_idx;
    logic       can_grant;
    logic [5:0] gnt_pay;

    assign elig = req_valid & req_mask;

    // Scan last+1, last+2, ... so the most recent winner goes last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!gnt_any && elig[last_q + 2'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = last_q + 2'(k);
            end
        end
    end

    always_comb begin
        gnt_pay = req_data[5:0];
        unique case (gnt_idx)
            2'd0: gnt_pay = req_data[5:0];
            2'd1: gnt_pay = req_data[11:6];
            2'd2: gnt_pay = req_data[17:12];
            2'd3: gnt_pay = req_data[23:18];
            default: gnt_pay = req_data[5:0];
        endcase
    end

    assign can_grant = (state_q == S_IDLE) & en
                     & ~ring_stall & gnt_any;

    assign req_ready = can_grant ? (4'b0001 << gnt_idx)
                                 : 4'b0000;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        tog_d       = tog_q;
        cnt_d       = cnt_q;
        inj_data_d  = inj_data_q;
        strobe_d    = 1'b0;
        pkt_count_d = pkt_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    // Bit 6 set keeps every packet distinct from 0x00.
                    inj_data_d  = {~tog_q, 1'b1, gnt_pay};
                    tog_d       = ~tog_q;
                    strobe_d    = 1'b1;
                    last_d      = gnt_idx;
                    pkt_count_d = pkt_count_q + 8'd1;
                    cnt_d       = HOLD_M1;
                    // HOLD=1 re-arbitrates every cycle, never busy.
                    state_d = (HOLD_M1 == 4'd0) ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                // Leave when this decrement brings the count to zero,
                // so the next grant lands exactly HOLD edges later.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 2'd3;
            tog_q       <= 1'b0;
            cnt_q       <= 4'd0;
            inj_data_q  <= 8'h00;
            strobe_q    <= 1'b0;
            pkt_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            tog_q       <= tog_d;
            cnt_q       <= cnt_d;
            inj_data_q  <= inj_data_d;
            strobe_q    <= strobe_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign inj_data   = inj_data_q;
    assign inj_strobe = strobe_q;
    assign busy       = (state_q == S_HOLD);
    assign pkt_count  = pkt_count_q;

endmodule
